regfile_boot_sequencer: RTL and testbench

//  Hardware boot/run controller for the single-cycle MIPS TopLevel: fills the register bank through its init write port, then hands the bank to the core.

---
 rtl/regfile_boot_sequencer_if.sv | 29 ++
 rtl/regfile_boot_sequencer.sv | 102 ++++++++++
 tb/tb_regfile_boot_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_boot_sequencer_if.sv
// regfile_boot_sequencer_if: host/register-bank signal bundle of the boot sequencer
interface regfile_boot_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              load_mode;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              halt_req;
    logic [DATA_W-1:0] escribir;
    logic [ADDR_W-1:0] dirIniciar;
    logic              EWIniciar;
    logic              sel;
    logic              core_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;
    modport master (
        output start, load_mode, load_data, load_valid, halt_req,
        input  load_ready, escribir, dirIniciar, EWIniciar, sel, core_en, busy, done, cycle_count
    );
    modport slave (
        input  start, load_mode, load_data, load_valid, halt_req,
        output load_ready, escribir, dirIniciar, EWIniciar, sel, core_en, busy, done, cycle_count
    );
endinterface

// File: rtl/regfile_boot_sequencer.sv
// regfile_boot_sequencer: fills the MIPS register bank through its init port, then runs the core
module regfile_boot_sequencer #(
    parameter int              DATA_W     = 32,
    parameter int              ADDR_W     = 5,
    parameter int              DEPTH      = 32,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0,
    parameter int              SKIP_R0    = 0,
    parameter int              RUN_CYCLES = 90,
    parameter int              CNT_W      = 16
) (
    input logic clk,
    input logic rst,
    regfile_boot_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(SKIP_R0);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(RUN_CYCLES == 0 ? 0 : RUN_CYCLES - 1);
    state_t            state, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr, addr_d, dir_d;
    logic [DATA_W-1:0] data_d;
    logic              ew_d, sel_d, en_d, busy_d, done_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept, last, stop;
    assign bus.load_ready = state == INIT && mode_q;
    assign accept = state == INIT && (!mode_q || bus.load_valid);
    assign last   = addr == LAST_ADDR;
    assign stop   = (RUN_CYCLES != 0 && bus.cycle_count == LAST_CNT) || bus.halt_req;
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        addr_d  = addr;
        dir_d   = bus.dirIniciar;
        data_d  = bus.escribir;
        ew_d    = 1'b1;
        sel_d   = bus.sel;
        en_d    = bus.core_en;
        busy_d  = bus.busy;
        done_d  = bus.done;
        cnt_d   = bus.cycle_count;
        case (state)
            IDLE, DONE: if (bus.start) begin
                state_d = INIT;
                mode_d  = bus.load_mode;
                addr_d  = FIRST_ADDR;
                cnt_d   = '0;
                sel_d   = 1'b0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end
            INIT: if (accept) begin
                dir_d   = addr;
                data_d  = mode_q ? bus.load_data : FILL_VALUE;
                ew_d    = 1'b0;
                addr_d  = last ? addr : addr + 1'b1;
                state_d = last ? RUN : INIT;
            end
            // first RUN cycle only hands the bank over, so sel never moves while a write is driven
            RUN: if (!bus.core_en) begin
                sel_d = 1'b1;
                en_d  = 1'b1;
            end else begin
                cnt_d = &bus.cycle_count ? bus.cycle_count : bus.cycle_count + 1'b1;
                if (stop) begin
                    state_d = DONE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mode_q          <= 1'b0;
            addr            <= '0;
            bus.escribir    <= '0;
            bus.dirIniciar  <= '0;
            bus.EWIniciar   <= 1'b1;
            bus.sel         <= 1'b0;
            bus.core_en     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.cycle_count <= '0;
        end else begin
            state           <= state_d;
            mode_q          <= mode_d;
            addr            <= addr_d;
            bus.escribir    <= data_d;
            bus.dirIniciar  <= dir_d;
            bus.EWIniciar   <= ew_d;
            bus.sel         <= sel_d;
            bus.core_en     <= en_d;
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.cycle_count <= cnt_d;
        end
    end
endmodule

// File: tb/tb_regfile_boot_sequencer.sv
// tb_regfile_boot_sequencer: directed checks of init fill, streaming, skip-r0, halt and reset behaviour
module tb_regfile_boot_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    regfile_boot_sequencer_if b1 ();
    regfile_boot_sequencer_if b2 ();
    regfile_boot_sequencer dut1 (.clk(clk), .rst(rst), .bus(b1));
    regfile_boot_sequencer #(.SKIP_R0(1), .FILL_VALUE(32'hDEADBEEF), .RUN_CYCLES(0)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    int total = 0;
    int bad = 0;
    int en1, en2, selbad;
    int wc1 [32];
    int wc2 [32];
    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // one clock: sample both register-bank write ports at the falling edge
    task automatic tick();
        @(negedge clk);
        if (b1.EWIniciar === 1'b0) begin
            mem1[b1.dirIniciar] = b1.escribir;
            wc1[b1.dirIniciar]++;
            if (b1.sel !== 1'b0) selbad++;
        end
        if (b2.EWIniciar === 1'b0) begin
            mem2[b2.dirIniciar] = b2.escribir;
            wc2[b2.dirIniciar]++;
            if (b2.sel !== 1'b0) selbad++;
        end
        if (b1.core_en === 1'b1) en1++;
        if (b2.core_en === 1'b1) en2++;
    endtask
    task automatic clr();
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 32'hFFFF_FFFF;
            mem2[i] = 32'hFFFF_FFFF;
            wc1[i] = 0;
            wc2[i] = 0;
        end
        en1 = 0;
        en2 = 0;
        selbad = 0;
    endtask
    task automatic start1(input logic m);
        b1.load_mode = m;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
    endtask
    task automatic wait_done1();
        for (int i = 0; i < 400 && b1.done !== 1'b1; i++) tick();
    endtask
    task automatic chk_rst1(input string p);
        chk({p, "_escribir"}, b1.escribir, 0);
        chk({p, "_dir"}, b1.dirIniciar, 0);
        chk({p, "_ew"}, b1.EWIniciar, 1);
        chk({p, "_sel"}, b1.sel, 0);
        chk({p, "_core_en"}, b1.core_en, 0);
        chk({p, "_busy"}, b1.busy, 0);
        chk({p, "_done"}, b1.done, 0);
        chk({p, "_ready"}, b1.load_ready, 0);
        chk({p, "_cnt"}, b1.cycle_count, 0);
    endtask
    task automatic chk_pass1(input string p, input logic [31:0] base, input bit inc);
        int e = 0;
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            n += wc1[i];
            if (wc1[i] != 1 || mem1[i] !== base + (inc ? 32'(i) : 32'd0)) e++;
        end
        chk({p, "_done"}, b1.done, 1);
        chk({p, "_writes"}, n, 32);
        chk({p, "_map"}, e, 0);
        chk({p, "_en_cycles"}, en1, 90);
        chk({p, "_cnt"}, b1.cycle_count, 90);
        chk({p, "_sel"}, b1.sel, 1);
        chk({p, "_core_en"}, b1.core_en, 0);
        chk({p, "_busy"}, b1.busy, 0);
        chk({p, "_sel_during_write"}, selbad, 0);
    endtask
    initial begin
        int j, ewbad, e, n;
        bit acc;
        {b1.start, b1.load_mode, b1.load_valid, b1.halt_req} = '0;
        {b2.start, b2.load_mode, b2.load_valid, b2.halt_req} = '0;
        b1.load_data = '0;
        b2.load_data = '0;
        clr();
        tick();
        tick();
        chk_rst1("rst");
        rst = 1'b0;
        tick();
        // constant fill then 90-cycle run
        clr();
        start1(1'b0);
        chk("t1_busy_start", b1.busy, 1);
        wait_done1();
        chk_pass1("t1", 32'h0, 1'b0);
        // restart from DONE; start and halt during INIT/RUN must be ignored
        clr();
        start1(1'b0);
        chk("t6_sel0", b1.sel, 0);
        chk("t6_cnt0", b1.cycle_count, 0);
        chk("t6_done0", b1.done, 0);
        repeat (5) tick();
        b1.start = 1'b1;
        b1.halt_req = 1'b1;
        tick();
        b1.start = 1'b0;
        b1.halt_req = 1'b0;
        for (int i = 0; i < 100 && b1.core_en !== 1'b1; i++) tick();
        chk("t6_reach_run", b1.core_en, 1);
        repeat (3) tick();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        wait_done1();
        chk_pass1("t6", 32'h0, 1'b0);
        // streamed load with a stall every third cycle
        clr();
        start1(1'b1);
        j = 0;
        ewbad = 0;
        for (int k = 0; k < 200 && j < 32; k++) begin
            b1.load_valid = (k % 3) != 2;
            b1.load_data = b1.load_valid ? 32'h1000 + 32'(j) : 32'hBAD0_BAD0;
            acc = b1.load_valid && b1.load_ready;
            tick();
            if (b1.EWIniciar !== !acc) ewbad++;
            if (acc) j++;
        end
        b1.load_valid = 1'b0;
        chk("t2_accepted", j, 32);
        chk("t2_ew_pattern", ewbad, 0);
        wait_done1();
        chk_pass1("t2", 32'h1000, 1'b1);
        chk("t2_ready_off", b1.load_ready, 0);
        // reset in the middle of INIT, then a clean pass
        clr();
        start1(1'b0);
        for (int i = 0; i < 100 && !(b1.EWIniciar === 1'b0 && b1.dirIniciar === 5'd10); i++) tick();
        chk("t5_at_addr10", b1.dirIniciar, 10);
        rst = 1'b1;
        tick();
        chk_rst1("t5");
        rst = 1'b0;
        tick();
        clr();
        start1(1'b0);
        wait_done1();
        chk_pass1("t5", 32'h0, 1'b0);
        // second instance: skip r0, 0xDEADBEEF fill, run until halt
        clr();
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        for (int i = 0; i < 100 && b2.core_en !== 1'b1; i++) tick();
        e = 0;
        n = 0;
        for (int i = 1; i < 32; i++) begin
            n += wc2[i];
            if (wc2[i] != 1 || mem2[i] !== 32'hDEADBEEF) e++;
        end
        chk("t3_writes", n, 31);
        chk("t3_map", e, 0);
        chk("t3_r0_untouched", wc2[0], 0);
        chk("t3_sel_during_write", selbad, 0);
        chk("t4_run_cnt0", b2.cycle_count, 0);
        repeat (16) tick();
        chk("t4_cnt16", b2.cycle_count, 16);
        chk("t4_not_done", b2.done, 0);
        b2.halt_req = 1'b1;
        tick();
        b2.halt_req = 1'b0;
        chk("t4_done", b2.done, 1);
        chk("t4_cnt", b2.cycle_count, 17);
        chk("t4_core_en", b2.core_en, 0);
        chk("t4_en_cycles", en2, 17);
        chk("t4_sel", b2.sel, 1);
        b2.halt_req = 1'b1;
        repeat (2) tick();
        b2.halt_req = 1'b0;
        chk("t4_halt_ignored", b2.cycle_count, 17);
        chk("t4_still_done", b2.done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
